// File: rtl/imem_line_responder_if.sv
// Fetch-side and backing-memory signals of the instruction line responder.
// The responder uses the slave modport; the IF stage / memory side uses master.
interface imem_line_responder_if;
    logic        req;
    logic [31:0] addr;
    logic        inv;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  req, addr, inv, mem_rdata, mem_ack,
        output instr, instr_valid, stall, mem_req, mem_addr
    );

    modport master (
        output req, addr, inv, mem_rdata, mem_ack,
        input  instr, instr_valid, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/imem_line_responder.sv
// Single-line instruction buffer: same-cycle hits, in-order beat refill on a miss.
// stall is meant to drive the PC enable as ~stall.
module imem_line_responder #(
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_line_responder_if.slave  bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 30 - OFF_W;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    logic [0:0]       state_q, state_d;
    logic             line_valid_q, line_valid_d;
    logic [TAG_W-1:0] line_tag_q, line_tag_d;
    logic [31:0]      fill_base_q, fill_base_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic             fill_kill_q, fill_kill_d;
    logic [31:0]      data_q [LINE_WORDS];
    logic [31:0]      data_d [LINE_WORDS];

    logic [TAG_W-1:0] tag_s;
    logic [OFF_W-1:0] idx_s;
    logic             hit_s;
    logic [31:0]      beat_addr_s;
    logic             addr_unused_s;

    assign tag_s         = bus.addr[31:OFF_W+2];
    assign idx_s         = bus.addr[OFF_W+1:2];
    assign addr_unused_s = ^bus.addr[1:0];
    assign hit_s         = (state_q == ST_IDLE) && line_valid_q && (tag_s == line_tag_q);
    assign beat_addr_s   = fill_base_q + {{TAG_W{1'b0}}, beat_q, 2'b00};

    // Fetch and memory outputs; all quiet while reset is asserted.
    always_comb begin
        bus.instr       = 32'h0000_0000;
        bus.instr_valid = 1'b0;
        bus.stall       = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_addr    = 32'h0000_0000;
        if (rst) begin
            bus.instr = 32'h0000_0000;
        end else if (state_q == ST_FILL) begin
            bus.stall    = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = beat_addr_s;
        end else begin
            bus.instr       = data_q[idx_s];
            bus.instr_valid = bus.req && hit_s;
            bus.stall       = bus.req && !hit_s;
        end
    end

    // Next-state: miss detection, beat sequencing and line commit.
    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        fill_base_d  = fill_base_q;
        beat_d       = beat_q;
        fill_kill_d  = fill_kill_q;
        data_d       = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.inv) begin
                    line_valid_d = 1'b0;
                end else begin
                    line_valid_d = line_valid_q;
                end
                if (bus.req && !hit_s) begin
                    state_d     = ST_FILL;
                    fill_base_d = {tag_s, {(OFF_W+2){1'b0}}};
                    beat_d      = {OFF_W{1'b0}};
                    fill_kill_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                // An invalidate mid-burst cannot abort it, only poison the result.
                if (bus.inv) begin
                    fill_kill_d = 1'b1;
                end else begin
                    fill_kill_d = fill_kill_q;
                end
                if (bus.mem_ack) begin
                    data_d[beat_q] = bus.mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        state_d      = ST_IDLE;
                        beat_d       = {OFF_W{1'b0}};
                        line_tag_d   = fill_base_q[31:OFF_W+2];
                        line_valid_d = !fill_kill_q && !bus.inv;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            line_valid_q <= 1'b0;
            line_tag_q   <= {TAG_W{1'b0}};
            fill_base_q  <= 32'h0000_0000;
            beat_q       <= {OFF_W{1'b0}};
            fill_kill_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            line_tag_q   <= line_tag_d;
            fill_base_q  <= fill_base_d;
            beat_q       <= beat_d;
            fill_kill_q  <= fill_kill_d;
        end
    end

    // Line data is never read before line_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
endmodule
